parking_system_4slot: RTL and testbench

//  Top-level controller for a 4-slot parking lot. Admits cars to the lowest free slot
//  and times each occupied slot in clock ticks. Computes the exit fee and sequences the

---
 rtl/parking_system_4slot.sv | 201 ++++++++++++++++++++
 tb/tb_parking_system_4slot.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_system_4slot.sv
// rtl/parking_system_4slot.sv - 4-slot parking lot controller with slot timers, fee and gate sequencing

// Gate/payment sequencer; owns occupancy and the slot of the car currently leaving.
module parking_fsm #(
  parameter int GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_pulse,
  input  logic       exit_pulse,
  input  logic       payment_received,
  input  logic [1:0] exit_car_select,
  output logic       entry_gate,
  output logic       exit_gate,
  output logic       fee_ready,
  output logic [3:0] occupancy,
  output logic       entry_accept,
  output logic [1:0] entry_slot,
  output logic       exit_accept,
  output logic       hold_valid,
  output logic [1:0] hold_slot
);

  localparam int GW = $clog2(GATE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    ENTRY_OPEN = 2'b01,
    WAIT_PAY   = 2'b10,
    EXIT_OPEN  = 2'b11
  } state_t;

  state_t        state;
  logic [GW-1:0] gate_cnt;
  logic [1:0]    exit_slot;

  // Event acceptance in IDLE: exit wins over a simultaneous entry; entry needs a free slot.
  always_comb begin
    exit_accept  = (state == IDLE) && exit_pulse && occupancy[exit_car_select];
    entry_accept = (state == IDLE) && entry_pulse && !exit_accept && !(&occupancy);
    entry_slot   = 2'd3;
    if (!occupancy[0])      entry_slot = 2'd0;
    else if (!occupancy[1]) entry_slot = 2'd1;
    else if (!occupancy[2]) entry_slot = 2'd2;
    hold_valid = (state == WAIT_PAY);
    hold_slot  = exit_slot;
  end

  // State machine with registered gate, fee_ready and occupancy outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      exit_slot  <= 2'd0;
      entry_gate <= 1'b0;
      exit_gate  <= 1'b0;
      fee_ready  <= 1'b0;
      occupancy  <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (exit_accept) begin
            exit_slot <= exit_car_select;
            fee_ready <= 1'b1;
            state     <= WAIT_PAY;
          end else if (entry_accept) begin
            occupancy[entry_slot] <= 1'b1;
            entry_gate            <= 1'b1;
            gate_cnt              <= '0;
            state                 <= ENTRY_OPEN;
          end
        end
        ENTRY_OPEN: begin
          if (gate_cnt == GW'(GATE_CYCLES - 1)) begin
            entry_gate <= 1'b0;
            state      <= IDLE;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
          end
        end
        WAIT_PAY: begin
          if (payment_received) begin
            fee_ready            <= 1'b0;
            exit_gate            <= 1'b1;
            occupancy[exit_slot] <= 1'b0;
            gate_cnt             <= '0;
            state                <= EXIT_OPEN;
          end
        end
        EXIT_OPEN: begin
          if (gate_cnt == GW'(GATE_CYCLES - 1)) begin
            exit_gate <= 1'b0;
            state     <= IDLE;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// Top level: slot timers, fee register and occupancy status around the sequencer.
module parking_system_4slot #(
  parameter int GATE_CYCLES = 4,
  parameter int RATE        = 1,
  parameter int TICK_DIV    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        entry_pulse,
  input  logic        exit_pulse_for_system,
  input  logic        payment_received,
  input  logic [1:0]  exit_car_select,
  output logic        entry_gate,
  output logic        exit_gate,
  output logic        full_led,
  output logic        fee_ready,
  output logic [3:0]  occupancy,
  output logic [2:0]  free_count,
  output logic [31:0] e0,
  output logic [31:0] e1,
  output logic [31:0] e2,
  output logic [31:0] e3,
  output logic [31:0] fee
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic          entry_accept;
  logic [1:0]    entry_slot;
  logic          exit_accept;
  logic          hold_valid;
  logic [1:0]    hold_slot;
  logic [31:0]   e [4];
  logic [31:0]   e_sel;
  logic [DW-1:0] div_cnt;
  logic          tick;

  parking_fsm #(.GATE_CYCLES(GATE_CYCLES)) FSM (
    .clk              (clk),
    .rst              (rst),
    .entry_pulse      (entry_pulse),
    .exit_pulse       (exit_pulse_for_system),
    .payment_received (payment_received),
    .exit_car_select  (exit_car_select),
    .entry_gate       (entry_gate),
    .exit_gate        (exit_gate),
    .fee_ready        (fee_ready),
    .occupancy        (occupancy),
    .entry_accept     (entry_accept),
    .entry_slot       (entry_slot),
    .exit_accept      (exit_accept),
    .hold_valid       (hold_valid),
    .hold_slot        (hold_slot)
  );

  assign e0    = e[0];
  assign e1    = e[1];
  assign e2    = e[2];
  assign e3    = e[3];
  assign e_sel = e[exit_car_select];
  assign tick  = (div_cnt == DW'(TICK_DIV - 1));

  // Occupancy status is purely combinational.
  always_comb begin
    full_led   = &occupancy;
    free_count = 3'd4 - ({2'b00, occupancy[0]} + {2'b00, occupancy[1]} +
                         {2'b00, occupancy[2]} + {2'b00, occupancy[3]});
  end

  // Timer prescaler: tick fires once every TICK_DIV cycles.
  always_ff @(posedge clk) begin
    if (!rst || tick) div_cnt <= '0;
    else              div_cnt <= div_cnt + 1'b1;
  end

  // Per-slot elapsed timers: reload on entry, freeze for the leaving car, saturate at max.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst) begin
        e[i] <= 32'd0;
      end else if (entry_accept && (entry_slot == 2'(i))) begin
        e[i] <= 32'd0;
      end else if (occupancy[i] && tick && (e[i] != 32'hFFFF_FFFF) &&
                   !(hold_valid && (hold_slot == 2'(i))) &&
                   !(exit_accept && (exit_car_select == 2'(i)))) begin
        e[i] <= e[i] + 32'd1;
      end
    end
  end

  // Fee captured from the leaving car's timer; held until the next accepted exit.
  always_ff @(posedge clk) begin
    if (!rst)             fee <= 32'd0;
    else if (exit_accept) fee <= e_sel * 32'(RATE);
  end

endmodule

// File: tb/tb_parking_system_4slot.sv
// tb/tb_parking_system_4slot.sv - directed and random checks of parking_system_4slot against a time-stamp model

module tb_parking_system_4slot;

  localparam int RATE = 1;
  localparam int GATE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        entry_pulse = 1'b0;
  logic        exit_pulse_for_system = 1'b0;
  logic        payment_received = 1'b0;
  logic [1:0]  exit_car_select = 2'd0;
  logic        entry_gate, exit_gate, full_led, fee_ready;
  logic [3:0]  occupancy;
  logic [2:0]  free_count;
  logic [31:0] e0, e1, e2, e3, fee;

  int errors = 0;
  int checks = 0;

  // Reference model: a slot's elapsed time is (now - entry time) unless frozen or free.
  longint      cyc = 0;
  longint      m_load [4];
  longint      m_hold [4];
  bit          m_occ  [4];
  int          m_phase;   // 0 idle, 1 entry gate open, 2 awaiting payment, 3 exit gate open
  int          m_left;
  int          m_frozen;
  logic [31:0] m_fee;

  parking_system_4slot dut (
    .clk                   (clk),
    .rst                   (rst),
    .entry_pulse           (entry_pulse),
    .exit_pulse_for_system (exit_pulse_for_system),
    .payment_received      (payment_received),
    .exit_car_select       (exit_car_select),
    .entry_gate            (entry_gate),
    .exit_gate             (exit_gate),
    .full_led              (full_led),
    .fee_ready             (fee_ready),
    .occupancy             (occupancy),
    .free_count            (free_count),
    .e0                    (e0),
    .e1                    (e1),
    .e2                    (e2),
    .e3                    (e3),
    .fee                   (fee)
  );

  always #5 clk = ~clk;

  function automatic longint m_elapsed(int i);
    longint v;
    if (m_occ[i] && m_frozen != i) v = cyc - m_load[i];
    else                           v = m_hold[i];
    if (v > 64'h0000_0000_FFFF_FFFF) v = 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    logic [3:0] occ_v;
    n = 0;
    occ_v = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      occ_v[i] = m_occ[i];
      if (m_occ[i]) n++;
    end
    chk("occupancy",  {28'd0, occupancy},      {28'd0, occ_v});
    chk("free_count", {29'd0, free_count},     32'(4 - n));
    chk("full_led",   {31'd0, full_led},       {31'd0, (n == 4)});
    chk("entry_gate", {31'd0, entry_gate},     {31'd0, (m_phase == 1)});
    chk("exit_gate",  {31'd0, exit_gate},      {31'd0, (m_phase == 3)});
    chk("fee_ready",  {31'd0, fee_ready},      {31'd0, (m_phase == 2)});
    chk("state",      {30'd0, dut.FSM.state},  32'(m_phase));
    chk("e0",         e0,                      32'(m_elapsed(0)));
    chk("e1",         e1,                      32'(m_elapsed(1)));
    chk("e2",         e2,                      32'(m_elapsed(2)));
    chk("e3",         e3,                      32'(m_elapsed(3)));
    chk("fee",        fee,                     m_fee);
  endtask

  // One clock: drive inputs, let the edge pass, advance the model, compare everything.
  task automatic step(input bit r, input bit ent, input bit ex, input bit pay, input logic [1:0] sel);
    longint pre [4];
    bit     placed;
    rst = r;
    entry_pulse = ent;
    exit_pulse_for_system = ex;
    payment_received = pay;
    exit_car_select = sel;
    for (int i = 0; i < 4; i++) pre[i] = m_elapsed(i);
    @(posedge clk);
    #1;
    entry_pulse = 1'b0;
    exit_pulse_for_system = 1'b0;
    payment_received = 1'b0;
    cyc++;
    if (!r) begin
      for (int i = 0; i < 4; i++) begin
        m_occ[i] = 1'b0;
        m_hold[i] = 0;
        m_load[i] = 0;
      end
      m_phase = 0;
      m_left = 0;
      m_frozen = -1;
      m_fee = 32'd0;
    end else begin
      case (m_phase)
        0: begin
          if (ex && m_occ[sel]) begin
            m_fee = 32'((pre[sel] * RATE) & 64'h0000_0000_FFFF_FFFF);
            m_hold[sel] = pre[sel];
            m_frozen = int'(sel);
            m_phase = 2;
          end else if (ent) begin
            placed = 1'b0;
            for (int j = 0; j < 4; j++) begin
              if (!m_occ[j] && !placed) begin
                placed = 1'b1;
                m_occ[j] = 1'b1;
                m_load[j] = cyc;
                m_phase = 1;
                m_left = GATE;
              end
            end
          end
        end
        2: begin
          if (pay) begin
            m_occ[m_frozen] = 1'b0;
            m_frozen = -1;
            m_phase = 3;
            m_left = GATE;
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) m_phase = 0;
        end
      endcase
    end
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_occ[i] = 1'b0;
      m_hold[i] = 0;
      m_load[i] = 0;
    end
    m_phase = 0;
    m_left = 0;
    m_frozen = -1;
    m_fee = 32'd0;

    // Reset held low for four cycles
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("reset_free_count", {29'd0, free_count}, 32'd4);

    // Single entry, then 20 cycles of timing
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("entry_occ", {28'd0, occupancy}, 32'd1);
    idle(20);
    chk("e0_after_20", e0, 32'd20);

    // Exit slot 0 and pay
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    chk("exit_fee", fee, 32'd20);
    idle(3);
    chk("e0_frozen", e0, 32'd20);
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    idle(4);
    chk("paid_occ", {28'd0, occupancy}, 32'd0);
    chk("fee_held", fee, 32'd20);

    // Re-entry reuses slot 0
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("reentry_e0", e0, 32'd0);
    idle(30);
    chk("e0_after_30", e0, 32'd30);

    // Fill the lot; an entry while a gate is open is dropped
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    idle(4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    idle(4);
    chk("full_occ", {28'd0, occupancy}, 32'd15);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("full_entry_gate", {31'd0, entry_gate}, 32'd0);

    // Vacate slot 2, then illegal exit on it and payment in idle
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd2);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
    idle(4);
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd2);
    chk("empty_exit_ignored", {31'd0, fee_ready}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    // Simultaneous entry and exit: exit wins
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
    chk("exit_priority_gate", {31'd0, entry_gate}, 32'd0);
    idle(2);
    // Reset during WAIT_PAY
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    chk("midreset_occ", {28'd0, occupancy}, 32'd0);
    chk("midreset_fee", fee, 32'd0);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(299) != 0,
           $urandom_range(3) == 0,
           $urandom_range(5) == 0,
           $urandom_range(4) == 0,
           2'($urandom_range(3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
